// File: rtl/prog_serializer.sv
// Program loader: buffers {last, word} entries in a small FIFO and shifts each word
// out serially, least-significant byte first and MSB first within each byte.
module prog_serializer #(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         wr_valid,
    input  logic [W-1:0] wr_data,
    input  logic         wr_last,
    output logic         wr_ready,
    output logic         ser_out,
    output logic         ser_en,
    output logic         busy,
    output logic         prog_done,
    output logic [15:0]  words_sent
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(W);

    typedef enum logic [1:0] {IDLE, SHIFT, GAP, DONE} state_t;

    logic [W:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wptr, r_rptr;
    logic [AW:0]   r_count;
    state_t        r_state;
    logic [W-1:0]  r_sh;
    logic [CW-1:0] r_bitcnt;
    logic          r_last;
    logic          r_ser_out, r_ser_en, r_prog_done;
    logic [15:0]   r_words;

    logic          w_full, w_empty, w_push, w_pop;
    logic [W:0]    w_head;
    logic [W-1:0]  w_swap;

    assign w_full  = (r_count == (AW+1)'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_head  = r_mem[r_rptr];

    // rst gates wr_ready so it reads 0 during reset without waiting for a clock
    assign wr_ready = rst && !w_full && (r_state != DONE) && !clear;
    assign w_push   = wr_valid && wr_ready;
    assign w_pop    = !clear && !w_empty && ((r_state == IDLE) || (r_state == GAP));

    // Byte-swap so a plain MSB-first shift yields byte 0 first, MSB first per byte
    always_comb begin
        w_swap = '0;
        for (int unsigned b = 0; b < W / 8; b++) begin
            w_swap[W-1-8*b -: 8] = w_head[8*b +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= {wr_last, wr_data};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (clear) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_sh        <= '0;
            r_bitcnt    <= '0;
            r_last      <= 1'b0;
            r_ser_out   <= 1'b0;
            r_ser_en    <= 1'b0;
            r_prog_done <= 1'b0;
            r_words     <= '0;
        end else if (clear) begin
            r_state     <= IDLE;
            r_ser_out   <= 1'b0;
            r_ser_en    <= 1'b0;
            r_prog_done <= 1'b0;
            r_words     <= '0;
        end else begin
            case (r_state)
                IDLE, GAP: begin
                    if (w_pop) begin
                        r_state   <= SHIFT;
                        r_ser_en  <= 1'b1;
                        r_ser_out <= w_swap[W-1];
                        r_sh      <= w_swap << 1;
                        r_bitcnt  <= '0;
                        r_last    <= w_head[W];
                    end else begin
                        r_state <= IDLE;
                    end
                end
                SHIFT: begin
                    if (r_bitcnt == CW'(W - 1)) begin
                        r_ser_en  <= 1'b0;
                        r_ser_out <= 1'b0;
                        if (r_words != 16'hFFFF) r_words <= r_words + 16'd1;
                        if (r_last) begin
                            r_state     <= DONE;
                            r_prog_done <= 1'b1;
                        end else begin
                            r_state <= GAP;
                        end
                    end else begin
                        r_ser_out <= r_sh[W-1];
                        r_sh      <= {r_sh[W-2:0], 1'b0};
                        r_bitcnt  <= r_bitcnt + CW'(1);
                    end
                end
                DONE:    r_state <= DONE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign ser_out    = r_ser_out;
    assign ser_en     = r_ser_en;
    assign prog_done  = r_prog_done;
    assign words_sent = r_words;
    assign busy       = (r_state == SHIFT) || (r_state == GAP) || !w_empty;

endmodule

// File: tb/tb_prog_serializer.sv
// Bench for prog_serializer: queue-based behavioural model checked every cycle,
// plus directed scenarios pinned with hand-computed literals.
module tb_prog_serializer;
    localparam int W     = 32;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        clear = 1'b0;
    logic        wr_valid = 1'b0;
    logic [31:0] wr_data = '0;
    logic        wr_last = 1'b0;
    logic        wr_ready, ser_out, ser_en, busy, prog_done;
    logic [15:0] words_sent;

    int vectors = 0;
    int miscompares = 0;

    prog_serializer #(.W(W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .clear(clear),
        .wr_valid(wr_valid), .wr_data(wr_data), .wr_last(wr_last),
        .wr_ready(wr_ready), .ser_out(ser_out), .ser_en(ser_en),
        .busy(busy), .prog_done(prog_done), .words_sent(words_sent)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Bit k of the serial stream for word w: byte k/8, MSB first within the byte
    function automatic logic bitof(input logic [31:0] w, input int k);
        logic [31:0] t;
        t = w;
        return t[8*(k/8) + 7 - (k%8)];
    endfunction

    // ---------------- behavioural model ----------------
    logic [32:0] mq[$];
    logic [31:0] m_cur;
    logic        m_cur_last;
    int          m_idx;
    bit          m_active, m_gap, m_done, m_push;
    logic [15:0] m_sent;
    logic        m_en, m_out;

    task automatic model_reset();
        mq.delete();
        m_active = 0; m_gap = 0; m_done = 0;
        m_sent = '0; m_en = 0; m_out = 0; m_idx = 0;
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst || clear) begin
            model_reset();
        end else begin
            m_push = wr_valid && (mq.size() < DEPTH) && !m_done;
            m_gap  = 0;
            if (m_active) begin
                if (m_idx == W - 1) begin
                    m_active = 0; m_en = 0; m_out = 0;
                    if (m_sent != 16'hFFFF) m_sent = m_sent + 16'd1;
                    if (m_cur_last) m_done = 1; else m_gap = 1;
                end else begin
                    m_idx = m_idx + 1;
                    m_out = bitof(m_cur, m_idx);
                end
            end else if (mq.size() > 0 && !m_done) begin
                {m_cur_last, m_cur} = mq.pop_front();
                m_active = 1; m_idx = 0; m_en = 1;
                m_out = bitof(m_cur, 0);
            end
            if (m_push) mq.push_back({wr_last, wr_data});
        end
    end

    // ---------------- compare process ----------------
    int          en_total = 0;
    int          en_starts = 0;
    logic        en_prev = 1'b0;
    logic [31:0] cap = '0;

    always @(negedge clk) begin
        chk("ser_en", ser_en, m_en);
        chk("ser_out", ser_out, m_out);
        chk("wr_ready", wr_ready, rst && (mq.size() < DEPTH) && !m_done && !clear);
        chk("busy", busy, m_active || m_gap || (mq.size() > 0));
        chk("prog_done", prog_done, m_done);
        chk("words_sent", words_sent, m_sent);
        if (ser_en) begin
            en_total++;
            cap = {cap[30:0], ser_out};
            if (!en_prev) en_starts++;
        end
        en_prev = ser_en;
    end

    // ---------------- stimulus helpers ----------------
    bit saw_notready = 0;

    task automatic push_word(input logic [31:0] d, input logic l);
        int   n;
        logic acc;
        n = 0; acc = 0;
        wr_valid = 1; wr_data = d; wr_last = l;
        while (!acc && n < 3000) begin
            @(negedge clk);
            acc = wr_ready;
            if (!acc) saw_notready = 1;
            @(posedge clk); #1;
            n++;
        end
        chk("push_accept", acc, 1);
    endtask

    task automatic do_clear();
        wr_valid = 0;
        clear = 1;
        @(posedge clk); #1;
        clear = 0;
        en_total = 0; en_starts = 0; cap = '0;
    endtask

    task automatic wait_done(input int maxc);
        int n;
        n = 0;
        while (!prog_done && n < maxc) begin
            @(posedge clk); #1;
            n++;
        end
        chk("done_timeout", prog_done, 1);
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int n, nw;
        #3;
        chk("rst_ser_en", ser_en, 0);
        chk("rst_wr_ready", wr_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_words", words_sent, 0);
        idle(2);
        rst = 1;
        #1 chk("ready_after_rst", wr_ready, 1);
        @(posedge clk); #1;

        // Single word
        do_clear();
        push_word(32'h00500093, 1'b1);
        wr_valid = 0;
        wait_done(200);
        chk("single_bits", en_total, 32);
        chk("single_stream", cap, 32'h93005000);
        chk("single_words", words_sent, 1);
        chk("single_ready", wr_ready, 0);

        // Back-to-back with backpressure
        do_clear();
        saw_notready = 0;
        for (int i = 1; i <= 6; i++) push_word(32'h1111_1111 * i, (i == 6));
        wr_valid = 0;
        wait_done(1000);
        chk("bp_saw_full", saw_notready, 1);
        chk("bp_bits", en_total, 192);
        chk("bp_bursts", en_starts, 6);
        chk("bp_words", words_sent, 6);

        // Underflow gap
        do_clear();
        push_word(32'hA5A5_0F0F, 1'b0);
        wr_valid = 0;
        idle(45);
        chk("uf_busy_idle", busy, 0);
        chk("uf_en_idle", ser_en, 0);
        idle(5);
        push_word(32'h1234_5678, 1'b1);
        wr_valid = 0;
        chk("uf_b_not_yet", ser_en, 0);
        idle(1);
        chk("uf_b_first_bit", ser_en, 1);
        wait_done(200);
        chk("uf_words", words_sent, 2);

        // Clear during the 10th bit of word 2 of 3
        do_clear();
        push_word(32'h0000_0001, 1'b0);
        push_word(32'h0000_0002, 1'b0);
        push_word(32'h0000_0003, 1'b1);
        wr_valid = 0;
        n = 0; nw = 0;
        while (nw < 10 && n < 500) begin
            @(posedge clk); #1;
            if (words_sent == 1 && ser_en) nw++;
            n++;
        end
        chk("clr_reach_bit10", nw, 10);
        clear = 1;
        @(posedge clk); #1;
        clear = 0;
        chk("clr_en", ser_en, 0);
        chk("clr_words", words_sent, 0);
        chk("clr_busy", busy, 0);
        en_total = 0; cap = '0;
        push_word(32'hDEADBEEF, 1'b1);
        wr_valid = 0;
        wait_done(200);
        chk("clr_next_stream", cap, 32'hEFBEADDE);
        chk("clr_next_bits", en_total, 32);

        // Async reset mid-shift
        do_clear();
        push_word(32'hCAFE_F00D, 1'b1);
        wr_valid = 0;
        idle(6);
        #2 rst = 0;
        #1;
        chk("arst_en", ser_en, 0);
        chk("arst_ready", wr_ready, 0);
        chk("arst_words", words_sent, 0);
        chk("arst_busy", busy, 0);
        @(posedge clk); #1;
        rst = 1;
        en_total = 0; cap = '0;
        push_word(32'h00500093, 1'b1);
        wr_valid = 0;
        wait_done(200);
        chk("arst_stream", cap, 32'h93005000);

        // Push in the same cycle GAP pops
        do_clear();
        push_word(32'h0101_0101, 1'b0);
        push_word(32'h0202_0202, 1'b0);
        push_word(32'h0303_0303, 1'b0);
        wr_valid = 0;
        n = 0;
        while (!(!ser_en && busy && words_sent == 1) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("pp_in_gap", words_sent, 1);
        push_word(32'h0404_0404, 1'b1);
        wr_valid = 0;
        wait_done(400);
        chk("pp_words", words_sent, 4);
        chk("pp_last_stream", cap, 32'h04040404);

        // Randomized programs
        for (int p = 0; p < 10; p++) begin
            do_clear();
            nw = $urandom_range(1, 7);
            for (int i = 0; i < nw; i++) begin
                wr_valid = 0;
                idle($urandom_range(0, 40));
                push_word($urandom, (i == nw - 1));
            end
            wr_valid = 0;
            wait_done(2000);
            chk("rnd_words", words_sent, nw);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
